// File: rtl/bomb_fuse_ctrl.sv
// Bomb fuse controller: arms the BCD fuse down-counter and sequences ARM/FUSE/EXPLODE/COOLDOWN.
// Optional BOMB_PAUSE_EN adds a pause input that freezes tick-driven progress.
module bomb_fuse_ctrl #(
    parameter int FUSE_SECONDS   = 3,
    parameter int BLINK_AT       = 1,
    parameter int EXPLODE_TICKS  = 2,
    parameter int COOLDOWN_TICKS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_sec,
    input  logic       place_req,
    input  logic       chain_hit,
`ifdef BOMB_PAUSE_EN
    input  logic       pause,
`endif
    input  logic [3:0] cnt_count,
    input  logic       cnt_tc,
    output logic       cnt_loadN,
    output logic       cnt_enable,
    output logic [3:0] cnt_datain,
    output logic       bomb_active,
    output logic       bomb_blink,
    output logic       exploding,
    output logic       explode_start,
    output logic       busy
);

    localparam int FUSE_V  = (FUSE_SECONDS < 1) ? 1 : (FUSE_SECONDS > 9) ? 9 : FUSE_SECONDS;
    localparam int BLINK_V = (BLINK_AT < 0) ? 0 : (BLINK_AT > 15) ? 15 : BLINK_AT;
    localparam int EXP_V   = (EXPLODE_TICKS < 1) ? 1 : (EXPLODE_TICKS > 15) ? 15 : EXPLODE_TICKS;
    localparam int COOL_V  = (COOLDOWN_TICKS < 0) ? 0 : (COOLDOWN_TICKS > 15) ? 15 : COOLDOWN_TICKS;

    localparam logic [3:0] FUSE_LOAD = 4'(FUSE_V);
    localparam logic [3:0] BLINK_LVL = 4'(BLINK_V);
    localparam logic [3:0] EXP_LAST  = 4'(EXP_V - 1);
    localparam logic [3:0] COOL_LAST = 4'((COOL_V == 0) ? 0 : COOL_V - 1);

    if (FUSE_SECONDS < 1 || FUSE_SECONDS > 9) begin : g_fuse_range
        $warning("bomb_fuse_ctrl: FUSE_SECONDS out of 1..9, clamped");
    end
    if (EXPLODE_TICKS < 1 || EXPLODE_TICKS > 15) begin : g_exp_range
        $warning("bomb_fuse_ctrl: EXPLODE_TICKS out of 1..15, clamped");
    end
    if (COOLDOWN_TICKS < 0 || COOLDOWN_TICKS > 15) begin : g_cool_range
        $warning("bomb_fuse_ctrl: COOLDOWN_TICKS out of 0..15, clamped");
    end
    if (BLINK_AT < 0 || BLINK_AT > 15) begin : g_blink_range
        $warning("bomb_fuse_ctrl: BLINK_AT out of 0..15, clamped");
    end

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARM      = 3'd1,
        S_FUSE     = 3'd2,
        S_EXPLODE  = 3'd3,
        S_COOLDOWN = 3'd4
    } state_t;

    state_t     state;
    logic [3:0] tcnt;
    logic       paused;
    logic       tick;

`ifdef BOMB_PAUSE_EN
    assign paused = pause;
`else
    assign paused = 1'b0;
`endif
    assign tick = one_sec & ~paused;

    // place_req is a request without ready: it is accepted only in IDLE and dropped otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            tcnt          <= 4'd0;
            explode_start <= 1'b0;
        end else begin
            explode_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (place_req) state <= S_ARM;
                end
                S_ARM: begin
                    state <= S_FUSE;
                end
                S_FUSE: begin
                    if (cnt_tc || chain_hit) begin
                        state         <= S_EXPLODE;
                        tcnt          <= 4'd0;
                        explode_start <= 1'b1;
                    end
                end
                S_EXPLODE: begin
                    if (tick) begin
                        if (tcnt == EXP_LAST) begin
                            state <= S_COOLDOWN;
                            tcnt  <= 4'd0;
                        end else begin
                            tcnt <= tcnt + 4'd1;
                        end
                    end
                end
                S_COOLDOWN: begin
                    if (COOL_V == 0) begin
                        state <= S_IDLE;
                    end else if (tick) begin
                        if (tcnt == COOL_LAST) begin
                            state <= S_IDLE;
                            tcnt  <= 4'd0;
                        end else begin
                            tcnt <= tcnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tcnt  <= 4'd0;
                end
            endcase
        end
    end

    // Gating with ~cnt_tc keeps the BCD counter from wrapping 0 -> 9 while the state catches up.
    assign cnt_loadN   = (state != S_ARM);
    assign cnt_enable  = (state == S_FUSE) & tick & ~cnt_tc;
    assign cnt_datain  = FUSE_LOAD;
    assign bomb_active = (state == S_ARM) | (state == S_FUSE);
    assign bomb_blink  = (state == S_FUSE) & (cnt_count <= BLINK_LVL);
    assign exploding   = (state == S_EXPLODE);
    assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_bomb_fuse_ctrl.sv
// Bench for bomb_fuse_ctrl: models the external BCD down-counter and predicts every output
// cycle by cycle from a remaining-ticks view of the bomb's life.
module tb_bomb_fuse_ctrl;

    localparam int FUSE_SECONDS   = 3;
    localparam int BLINK_AT       = 1;
    localparam int EXPLODE_TICKS  = 2;
    localparam int COOLDOWN_TICKS = 1;
`ifdef BOMB_PAUSE_EN
    localparam bit HAS_PAUSE = 1'b1;
`else
    localparam bit HAS_PAUSE = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       one_sec = 1'b0;
    logic       place_req = 1'b0;
    logic       chain_hit = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] cnt_count;
    logic       cnt_tc;
    logic       cnt_loadN, cnt_enable;
    logic [3:0] cnt_datain;
    logic       bomb_active, bomb_blink, exploding, explode_start, busy;

    bomb_fuse_ctrl #(
        .FUSE_SECONDS  (FUSE_SECONDS),
        .BLINK_AT      (BLINK_AT),
        .EXPLODE_TICKS (EXPLODE_TICKS),
        .COOLDOWN_TICKS(COOLDOWN_TICKS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .one_sec      (one_sec),
        .place_req    (place_req),
        .chain_hit    (chain_hit),
`ifdef BOMB_PAUSE_EN
        .pause        (pause),
`endif
        .cnt_count    (cnt_count),
        .cnt_tc       (cnt_tc),
        .cnt_loadN    (cnt_loadN),
        .cnt_enable   (cnt_enable),
        .cnt_datain   (cnt_datain),
        .bomb_active  (bomb_active),
        .bomb_blink   (bomb_blink),
        .exploding    (exploding),
        .explode_start(explode_start),
        .busy         (busy)
    );

    // external 4-bit BCD down counter (wraps 0 -> 9 when enabled at 0)
    logic [3:0] cnt_q = 4'd7;
    always @(posedge clk) begin
        if (!cnt_loadN)      cnt_q <= cnt_datain;
        else if (cnt_enable) cnt_q <= (cnt_q == 4'd0) ? 4'd9 : cnt_q - 4'd1;
    end
    assign cnt_count = cnt_q;
    assign cnt_tc    = (cnt_q == 4'd0);

    // scoreboard
    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, want);
        end
    endtask

    // reference model: phase 0 idle, 1 arming, 2 fusing, 3 blast, 4 cooldown
    int m_ph        = 0;
    int m_fuse_left = 0;
    int m_ticks     = 0;
    bit m_start     = 1'b0;

    task automatic model_step(input bit r, input bit tk, input bit pr, input bit ch);
        bit nstart;
        nstart = 1'b0;
        if (r) begin
            m_ph = 0;
        end else begin
            case (m_ph)
                0: if (pr) m_ph = 1;
                1: begin m_ph = 2; m_fuse_left = FUSE_SECONDS; end
                2: begin
                    if (m_fuse_left == 0 || ch) begin
                        m_ph = 3; m_ticks = EXPLODE_TICKS; nstart = 1'b1;
                    end else if (tk) begin
                        m_fuse_left--;
                    end
                end
                3: if (tk) begin
                    m_ticks--;
                    if (m_ticks == 0) begin m_ph = 4; m_ticks = COOLDOWN_TICKS; end
                end
                default: begin
                    if (m_ticks == 0) m_ph = 0;
                    else if (tk) begin
                        m_ticks--;
                        if (m_ticks == 0) m_ph = 0;
                    end
                end
            endcase
        end
        m_start = nstart;
    endtask

    // driver: one clock cycle, inputs applied at negedge, outputs checked before the posedge
    task automatic cycle(input bit r, input bit os, input bit pr, input bit ch, input bit pz);
        bit pz_e;
        bit tc_m;
        logic [10:0] want;
        pz_e      = HAS_PAUSE ? pz : 1'b0;
        reset     = r;
        one_sec   = os;
        place_req = pr;
        chain_hit = ch;
        pause     = pz_e;
        #1;
        tc_m = (m_fuse_left == 0);
        want = {m_ph != 1, (m_ph == 2) && os && !tc_m && !pz_e, 4'(FUSE_SECONDS),
                (m_ph == 1) || (m_ph == 2), (m_ph == 2) && (m_fuse_left <= BLINK_AT),
                m_ph == 3, m_start, m_ph != 0};
        check("outs", {5'd0, cnt_loadN, cnt_enable, cnt_datain, bomb_active, bomb_blink,
                       exploding, explode_start, busy}, {5'd0, want});
        if (m_ph == 2) check("count", {12'd0, cnt_count}, 16'(m_fuse_left));
        model_step(r, os && !pz_e, pr, ch);
        @(negedge clk);
    endtask

    int tick_per   = 4;
    int tick_phase = 0;
    function automatic bit next_tick();
        bit t;
        t = (tick_phase == 0);
        tick_phase = (tick_phase + 1) % tick_per;
        return t;
    endfunction

    task automatic run(input int n, input bit pr, input bit ch, input bit pz);
        for (int i = 0; i < n; i++) cycle(1'b0, next_tick(), pr, ch, pz);
    endtask

    // run idle ticks until the model sits in FUSE with the given count, bounded
    task automatic wait_fuse(input int target);
        int budget;
        budget = 200;
        while (!(m_ph == 2 && m_fuse_left == target) && budget > 0) begin
            cycle(1'b0, next_tick(), 1'b0, 1'b0, 1'b0);
            budget--;
        end
        if (budget == 0) check("wait_fuse_timeout", 16'd0, 16'd1);
    endtask

    initial begin
        bit pz_r;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_ph = 0; m_start = 1'b0;

        // reset held with requests present: stays idle
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // plain life cycle: place pulse, ticks every 4 cycles
        tick_per = 4; tick_phase = 1;
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run(40, 1'b0, 1'b0, 1'b0);

        // one_sec held high: counter must stop at 0, single explode_start
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("nowrap", {12'd0, cnt_count}, 16'd0);
        run(10, 1'b0, 1'b0, 1'b0);

        // chain hit at count 2
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_fuse(2);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run(30, 1'b0, 1'b0, 1'b0);

        // place_req held through the whole life: dropped while busy, re-arms as busy falls
        run(80, 1'b1, 1'b0, 1'b0);
        run(30, 1'b0, 1'b0, 1'b0);

        // reset mid-fuse at count 2, then arm again
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_fuse(2);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run(40, 1'b0, 1'b0, 1'b0);

        // pause for five ticks at count 2, then release
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_fuse(2);
        run(20, 1'b0, 1'b0, 1'b1);
        check("pause_hold", {12'd0, cnt_count}, HAS_PAUSE ? 16'd2 : 16'(m_fuse_left));
        run(40, 1'b0, 1'b0, 1'b0);

        // randomized traffic
        pz_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) tick_per = $urandom_range(1, 6);
            if ($urandom_range(0, 19) == 0) pz_r = ~pz_r;
            cycle($urandom_range(0, 299) == 0, next_tick(), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 29) == 0, pz_r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
